ahb_cache_bridge: RTL

AHB-Lite slave that sits directly upstream of the write-back cache controller. It converts Hazard3 bus transfers into the controller's level-style rd/wr request interface, which uses busy and hit feedback. The bridge generates byte masks from HSIZE/HADDR and holds address, data and mask stable for the whole operation. It retries requests the controller silently drops, for example reads issued before DRAM init completes, and stretches the AHB data phase with HREADYOUT.

---
 rtl/ahb_cache_bridge_if.sv | 40 ++++
 rtl/ahb_cache_bridge.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ahb_cache_bridge_if.sv
// AHB-Lite slave port plus the level-style request port of the write-back cache controller.
// The bridge uses "slave"; the bus master / controller model uses "master".
interface ahb_cache_bridge_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              ahbls_hready;
    logic              ahbls_hreadyout;
    logic              ahbls_hresp;
    logic [W_ADDR-1:0] ahbls_haddr;
    logic              ahbls_hwrite;
    logic [1:0]        ahbls_htrans;
    logic [2:0]        ahbls_hsize;
    logic              ahbls_hsel;
    logic [W_DATA-1:0] ahbls_hwdata;
    logic [W_DATA-1:0] ahbls_hrdata;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_DATA-1:0] mem_wdata;
    logic [3:0]        mem_mask;
    logic [W_DATA-1:0] mem_rdata;
    logic              mem_busy;
    logic              mem_hit;

    modport slave (
        input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
               ahbls_hsel, ahbls_hwdata, mem_rdata, mem_busy, mem_hit,
        output ahbls_hreadyout, ahbls_hresp, ahbls_hrdata,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
               ahbls_hsel, ahbls_hwdata, mem_rdata, mem_busy, mem_hit,
        input  ahbls_hreadyout, ahbls_hresp, ahbls_hrdata,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/ahb_cache_bridge.sv
// AHB-Lite to cache-controller bridge: one transfer at a time, retries requests the
// controller drops (no busy, no hit) and stretches the data phase with HREADYOUT.
module ahb_cache_bridge #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                clk,
    input  logic                rst,
    ahb_cache_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_RISE, WAIT_FALL, ERR1, ERR2
    } state_t;

    state_t            state_q, state_d;
    logic              hwrite_q, hwrite_d;
    logic              first_q, first_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [3:0]        mask_q, mask_d;
    logic [W_DATA-1:0] wdata_q, wdata_d;
    logic [W_DATA-1:0] hrdata_q, hrdata_d;

    logic              accept;
    logic              strobe;
    logic              hreadyout;
    logic              hresp;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lsb;
            3'd1:    m = lsb[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic illegal_xfer(input logic [2:0] size, input logic [1:0] lsb);
        return (size > 3'd2) || (size == 3'd1 && lsb[0]) || (size == 3'd2 && lsb != 2'b00);
    endfunction

    assign accept = bus.ahbls_hsel && bus.ahbls_hready &&
                    (bus.ahbls_htrans == 2'b10 || bus.ahbls_htrans == 2'b11);

    always_comb begin
        state_d   = state_q;
        hwrite_d  = hwrite_q;
        first_d   = first_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        hrdata_d  = hrdata_q;
        strobe    = 1'b0;
        hreadyout = 1'b0;
        hresp     = 1'b0;

        case (state_q)
            IDLE: begin
                hreadyout = 1'b1;
                if (accept) begin
                    if (illegal_xfer(bus.ahbls_hsize, bus.ahbls_haddr[1:0])) begin
                        state_d = ERR1;
                    end else begin
                        state_d  = REQ;
                        addr_d   = {2'b00, bus.ahbls_haddr[W_ADDR-1:2]};
                        hwrite_d = bus.ahbls_hwrite;
                        mask_d   = lane_mask(bus.ahbls_hsize, bus.ahbls_haddr[1:0]);
                        first_d  = 1'b1;
                    end
                end
            end
            REQ: begin
                // Holding off while busy keeps strobes out of a controller operation.
                if (!bus.mem_busy) begin
                    strobe  = 1'b1;
                    first_d = 1'b0;
                    if (hwrite_q && first_q) begin
                        wdata_d = bus.ahbls_hwdata;
                    end
                    if (!hwrite_q && bus.mem_hit) begin
                        hrdata_d = bus.mem_rdata;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_RISE;
                    end
                end
            end
            WAIT_RISE: begin
                // No busy the cycle after a strobe means the controller dropped it.
                state_d = bus.mem_busy ? WAIT_FALL : REQ;
            end
            WAIT_FALL: begin
                if (!bus.mem_busy) begin
                    state_d = hwrite_q ? IDLE : REQ;
                end
            end
            ERR1: begin
                hresp   = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                hreadyout = 1'b1;
                hresp     = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hwrite_q <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hwrite_q <= hwrite_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    // The first write strobe passes HWDATA straight through; retries use the registered copy.
    assign bus.mem_wdata       = (state_q == REQ && hwrite_q && first_q) ? bus.ahbls_hwdata : wdata_q;
    assign bus.mem_rd_en       = strobe && !hwrite_q;
    assign bus.mem_wr_en       = strobe && hwrite_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_mask        = mask_q;
    assign bus.ahbls_hreadyout = hreadyout;
    assign bus.ahbls_hresp     = hresp;
    assign bus.ahbls_hrdata    = hrdata_q;

endmodule
